// File: rtl/divisor_arbiter.sv
// rtl/divisor_arbiter.sv - round-robin front end sharing one sequential signed divider
//
// Purpose:
//   Lets N_REQ requesting datapaths share a single sequential signed divider.
//   A round-robin search picks one requester. Its operands are captured, the
//   divider is started, and the quotient/remainder are returned to that requester.
//   Only one division is in flight at a time.
//
// Ports:
//   CLK, RSTa        clock (rising edge) and asynchronous active-low reset
//   Req              per-requester request level
//   NumIn, DenIn     packed operands, slot i = [i*tamanyo +: tamanyo]
//   Gnt              one-hot pulse: operands of the slot were captured
//   RspValid         one-hot pulse: Coc_o/Res_o belong to that slot
//   Coc_o, Res_o     quotient/remainder of the last completed operation (held)
//   DivZero          flags a divide-by-zero response (bypass build only)
//   Busy             high whenever the FSM is outside IDLE
//   Div_Start        start pulse to the divider
//   Div_Num, Div_Den operands presented to the divider (held during the operation)
//   Div_Coc, Div_Res divider results
//   Div_Done         divider completion pulse
//
// Optional feature macro: DIV_ZERO_BYPASS_EN
//   When defined, a winner whose divisor is zero never reaches the divider.
//   The response is produced directly: Coc_o = all ones, Res_o = dividend, DivZero = 1.
//   When undefined, a zero divisor is forwarded like any other operand and
//   DivZero stays 0.

module divisor_arbiter #(
  parameter int N_REQ   = 4,
  parameter int tamanyo = 32
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  input  logic [N_REQ-1:0]           Req,
  input  logic [N_REQ*tamanyo-1:0]   NumIn,
  input  logic [N_REQ*tamanyo-1:0]   DenIn,
  output logic [N_REQ-1:0]           Gnt,
  output logic [N_REQ-1:0]           RspValid,
  output logic [tamanyo-1:0]         Coc_o,
  output logic [tamanyo-1:0]         Res_o,
  output logic                       DivZero,
  output logic                       Busy,
  output logic                       Div_Start,
  output logic [tamanyo-1:0]         Div_Num,
  output logic [tamanyo-1:0]         Div_Den,
  input  logic [tamanyo-1:0]         Div_Coc,
  input  logic [tamanyo-1:0]         Div_Res,
  input  logic                       Div_Done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, next_state;

  // Control/datapath registers and their next values
  logic [IW-1:0]      ptr, ptr_d;
  logic [IW-1:0]      idx, idx_d;
  logic [tamanyo-1:0] num_q, num_d;
  logic [tamanyo-1:0] den_q, den_d;
  logic               byp_q, byp_d;

  // Next values of the registered outputs
  logic [N_REQ-1:0]   gnt_d, rsp_d;
  logic [tamanyo-1:0] coc_d, res_d, dnum_d, dden_d;
  logic               dz_d, busy_d, start_d;

  // Unpacked per-slot views of the packed operand buses
  logic [tamanyo-1:0] num_slot [N_REQ];
  logic [tamanyo-1:0] den_slot [N_REQ];

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : g_unpack
      assign num_slot[g] = NumIn[g*tamanyo +: tamanyo];
      assign den_slot[g] = DenIn[g*tamanyo +: tamanyo];
    end
  endgenerate

  // (base + k) mod N_REQ for k in [0, N_REQ); also works when N_REQ is not a power of two
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int j;
    j = int'(base) + k;
    if (j >= N_REQ) j = j - N_REQ;
    return IW'(j);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first requester at or above ptr, wrapping to 0
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] sel;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sel       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sel = wrap_add(ptr, k);
      if (!win_found && Req[sel]) begin
        win_found = 1'b1;
        win_idx   = sel;
      end
    end
  end

  logic win_den_zero;
`ifdef DIV_ZERO_BYPASS_EN
  assign win_den_zero = (den_slot[win_idx] == '0);
`else
  assign win_den_zero = 1'b0;
`endif

  // State register (plus the datapath/output registers it sequences)
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      num_q     <= '0;
      den_q     <= '0;
      byp_q     <= 1'b0;
      Gnt       <= '0;
      RspValid  <= '0;
      Coc_o     <= '0;
      Res_o     <= '0;
      DivZero   <= 1'b0;
      Busy      <= 1'b0;
      Div_Start <= 1'b0;
      Div_Num   <= '0;
      Div_Den   <= '0;
    end else begin
      state     <= next_state;
      ptr       <= ptr_d;
      idx       <= idx_d;
      num_q     <= num_d;
      den_q     <= den_d;
      byp_q     <= byp_d;
      Gnt       <= gnt_d;
      RspValid  <= rsp_d;
      Coc_o     <= coc_d;
      Res_o     <= res_d;
      DivZero   <= dz_d;
      Busy      <= busy_d;
      Div_Start <= start_d;
      Div_Num   <= dnum_d;
      Div_Den   <= dden_d;
    end
  end

  // Next-state logic and operand capture
  always_comb begin
    next_state = state;
    ptr_d      = ptr;
    idx_d      = idx;
    num_d      = num_q;
    den_d      = den_q;
    byp_d      = byp_q;
    case (state)
      IDLE: begin
        if (win_found) begin
          idx_d      = win_idx;
          num_d      = num_slot[win_idx];
          den_d      = den_slot[win_idx];
          byp_d      = win_den_zero;
          next_state = win_den_zero ? RESP : ISSUE;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (Div_Done) next_state = RESP;
      end
      RESP: begin
        // The slot just served drops to lowest priority
        ptr_d      = wrap_add(idx, 1);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic. The pulse outputs are registered from the current state, so
  // they become visible in the cycle after that state. Busy follows the state
  // directly. Results are captured on the edge that sees Div_Done, so they are
  // already stable when RspValid rises.
  always_comb begin
    gnt_d   = '0;
    rsp_d   = '0;
    dz_d    = 1'b0;
    start_d = 1'b0;
    busy_d  = (next_state != IDLE);
    coc_d   = Coc_o;
    res_d   = Res_o;
    dnum_d  = Div_Num;
    dden_d  = Div_Den;
    case (state)
      IDLE: begin
        if (win_found && win_den_zero) begin
          coc_d = '1;
          res_d = num_slot[win_idx];
        end
      end
      ISSUE: begin
        gnt_d   = onehot(idx);
        start_d = 1'b1;
        dnum_d  = num_q;
        dden_d  = den_q;
      end
      WAIT: begin
        if (Div_Done) begin
          coc_d = Div_Coc;
          res_d = Div_Res;
        end
      end
      RESP: begin
        rsp_d = onehot(idx);
        // A bypassed operation never passed through ISSUE, so its grant goes out here
        if (byp_q) gnt_d = onehot(idx);
        dz_d  = byp_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_divisor_arbiter.sv
// tb/tb_divisor_arbiter.sv - self-checking bench for divisor_arbiter with a behavioural divider

module tb_divisor_arbiter;

  localparam int N       = 4;
  localparam int W       = 32;
  localparam int DIV_LAT = 4;

`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RSTa = 1'b0;
  logic [N-1:0]   Req = '0;
  logic [N*W-1:0] NumIn = '0;
  logic [N*W-1:0] DenIn = '0;
  logic [N-1:0]   Gnt, RspValid;
  logic [W-1:0]   Coc_o, Res_o, Div_Num, Div_Den;
  logic           DivZero, Busy, Div_Start;
  logic [W-1:0]   Div_Coc = '0;
  logic [W-1:0]   Div_Res = '0;
  logic           Div_Done = 1'b0;

  divisor_arbiter #(.N_REQ(N), .tamanyo(W)) dut (
    .CLK(CLK), .RSTa(RSTa), .Req(Req), .NumIn(NumIn), .DenIn(DenIn),
    .Gnt(Gnt), .RspValid(RspValid), .Coc_o(Coc_o), .Res_o(Res_o),
    .DivZero(DivZero), .Busy(Busy), .Div_Start(Div_Start),
    .Div_Num(Div_Num), .Div_Den(Div_Den), .Div_Coc(Div_Coc),
    .Div_Res(Div_Res), .Div_Done(Div_Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           slot;
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] coc;
    logic [W-1:0] res;
    logic         dz;
    int           starts;
  } vec_t;

  typedef struct {
    int           slot;
    logic [W-1:0] coc;
    logic [W-1:0] res;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   gq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  int   start_cnt = 0;
  int   gnt_cnt = 0;
  int   rsp_cnt = 0;
  bit   inj_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
  endtask

  function automatic logic [N-1:0] oh(input int s);
    logic [N-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural divider: latches operands on Div_Start, pulses Div_Done DIV_LAT cycles later
  logic [W-1:0] dv_num = '0;
  logic [W-1:0] dv_den = '0;
  int           dv_cnt = 0;
  always @(negedge CLK) begin
    Div_Done = 1'b0;
    if (!RSTa) begin
      dv_cnt = 0;
    end else if (inj_done) begin
      Div_Done = 1'b1;
      Div_Coc  = 32'hDEAD_BEEF;
      Div_Res  = 32'h0BAD_F00D;
    end else if (Div_Start) begin
      dv_num = Div_Num;
      dv_den = Div_Den;
      dv_cnt = DIV_LAT;
      start_cnt++;
    end else if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        Div_Done = 1'b1;
        done_cyc = cyc;
        if (dv_den == '0) begin
          Div_Coc = '1;
          Div_Res = dv_num;
        end else begin
          Div_Coc = $signed(dv_num) / $signed(dv_den);
          Div_Res = $signed(dv_num) % $signed(dv_den);
        end
      end
    end
  end

  // Monitor: grants against expected grant order, responses against the scoreboard
  exp_t mon_e;
  int   mon_s;
  always @(negedge CLK) begin
    if (RSTa) begin
      if (Gnt != '0) begin
        gnt_cnt++;
        if (gq.size() == 0) check("gnt_unexpected", 64'(Gnt), 64'(0));
        else begin
          mon_s = gq.pop_front();
          check("gnt_slot", 64'(Gnt), 64'(oh(mon_s)));
        end
      end
      if (RspValid != '0) begin
        rsp_cnt++;
        if (sb.size() == 0) check("rsp_unexpected", 64'(RspValid), 64'(0));
        else begin
          mon_e = sb.pop_front();
          check("rsp_slot", 64'(RspValid), 64'(oh(mon_e.slot)));
          check("rsp_coc", 64'(Coc_o), 64'(mon_e.coc));
          check("rsp_res", 64'(Res_o), 64'(mon_e.res));
          check("rsp_divzero", 64'(DivZero), 64'(mon_e.dz));
          if (!mon_e.dz) check("rsp_latency", 64'(cyc - done_cyc), 64'(2));
        end
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic set_ops(input int s, input logic [W-1:0] num, input logic [W-1:0] den);
    NumIn[s*W +: W] = num;
    DenIn[s*W +: W] = den;
  endtask

  task automatic expect_rsp(input int s, input logic [W-1:0] coc, input logic [W-1:0] res, input logic dz);
    exp_t e;
    e.slot = s;
    e.coc  = coc;
    e.res  = res;
    e.dz   = dz;
    sb.push_back(e);
    gq.push_back(s);
  endtask

  task automatic wait_gnt(input int s, input string nm);
    int k = 0;
    while (!Gnt[s] && k < 60) begin
      step();
      k++;
    end
    check(nm, 64'(Gnt[s]), 64'(1));
  endtask

  task automatic wait_rsp(input int target, input string nm);
    int k = 0;
    while (rsp_cnt < target && k < 200) begin
      step();
      k++;
    end
    check(nm, 64'(rsp_cnt), 64'(target));
  endtask

  task automatic check_zero(input string p);
    check({p, "_gnt"}, 64'(Gnt), 64'(0));
    check({p, "_rspvalid"}, 64'(RspValid), 64'(0));
    check({p, "_coc"}, 64'(Coc_o), 64'(0));
    check({p, "_res"}, 64'(Res_o), 64'(0));
    check({p, "_divzero"}, 64'(DivZero), 64'(0));
    check({p, "_busy"}, 64'(Busy), 64'(0));
    check({p, "_start"}, 64'(Div_Start), 64'(0));
    check({p, "_divnum"}, 64'(Div_Num), 64'(0));
    check({p, "_divden"}, 64'(Div_Den), 64'(0));
  endtask

  task automatic do_reset();
    Req  = '0;
    RSTa = 1'b0;
    step();
    step();
    RSTa = 1'b1;
    step();
  endtask

  task automatic run_op(input vec_t v);
    int tgt;
    tgt = rsp_cnt + 1;
    expect_rsp(v.slot, v.coc, v.res, v.dz);
    set_ops(v.slot, v.num, v.den);
    Req[v.slot] = 1'b1;
    wait_gnt(v.slot, "vec_gnt_wait");
    Req[v.slot] = 1'b0;
    wait_rsp(tgt, "vec_rsp_wait");
  endtask

  function automatic vec_t mk(int slot, int num, int den, int coc, int res, bit dz, int starts);
    vec_t v;
    v.slot   = slot;
    v.num    = num;
    v.den    = den;
    v.coc    = coc;
    v.res    = res;
    v.dz     = dz;
    v.starts = starts;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    int   s0, r0, g0, k;

    vecs[0] = mk(0, 100, 7, 14, 2, 1'b0, 1);
    vecs[1] = mk(1, -100, 7, -14, -2, 1'b0, 1);
    vecs[2] = mk(3, -100, -7, 14, -2, 1'b0, 1);
    vecs[3] = mk(2, 100, -7, -14, 2, 1'b0, 1);
    vecs[4] = mk(1, 7, 100, 0, 7, 1'b0, 1);
    vecs[5] = mk(0, 32'h7FFF_FFFF, 1, 32'h7FFF_FFFF, 0, 1'b0, 1);
    vecs[6] = mk(3, 1000000, 3, 333333, 1, 1'b0, 1);
    vecs[7] = mk(2, 55, 0, -1, 55, BYP, BYP ? 0 : 1);

    // Reset state
    step();
    check_zero("reset");
    RSTa = 1'b1;
    step();
    check_zero("post_reset");

    // Single request: grant one cycle after sampling, start pulse with latched operands
    r0 = rsp_cnt;
    set_ops(0, 100, 7);
    expect_rsp(0, 14, 2, 1'b0);
    Req = 4'b0001;
    step();
    check("t1_busy", 64'(Busy), 64'(1));
    check("t1_gnt_early", 64'(Gnt), 64'(0));
    step();
    check("t1_gnt", 64'(Gnt), 64'(4'b0001));
    check("t1_start", 64'(Div_Start), 64'(1));
    check("t1_divnum", 64'(Div_Num), 64'(100));
    check("t1_divden", 64'(Div_Den), 64'(7));
    Req = '0;
    wait_rsp(r0 + 1, "t1_rsp_wait");
    step();
    check("t1_coc_held", 64'(Coc_o), 64'(14));
    check("t1_busy_idle", 64'(Busy), 64'(0));

    // Div_Done outside WAIT must be ignored
    r0 = rsp_cnt;
    inj_done = 1'b1;
    step();
    inj_done = 1'b0;
    step();
    step();
    check("spur_coc", 64'(Coc_o), 64'(14));
    check("spur_res", 64'(Res_o), 64'(2));
    check("spur_busy", 64'(Busy), 64'(0));
    check("spur_rsp", 64'(rsp_cnt), 64'(r0));

    // Table of single operations including signed and zero-divisor cases
    for (int i = 0; i < 8; i++) begin
      s0 = start_cnt;
      run_op(vecs[i]);
      check($sformatf("vec%0d_starts", i), 64'(start_cnt - s0), 64'(vecs[i].starts));
    end

    // Round robin with all requesters held: order 0,1,2,3,0
    do_reset();
    set_ops(0, 1000, 3);
    set_ops(1, 2000, 7);
    set_ops(2, -3000, 11);
    set_ops(3, 4000, -9);
    expect_rsp(0, 333, 1, 1'b0);
    expect_rsp(1, 285, 5, 1'b0);
    expect_rsp(2, -272, -8, 1'b0);
    expect_rsp(3, -444, 4, 1'b0);
    expect_rsp(0, 333, 1, 1'b0);
    g0 = gnt_cnt;
    r0 = rsp_cnt;
    Req = 4'b1111;
    k = 0;
    while (gnt_cnt < g0 + 5 && k < 300) begin
      step();
      k++;
    end
    Req = '0;
    check("rr_grants", 64'(gnt_cnt - g0), 64'(5));
    wait_rsp(r0 + 5, "rr_rsp_wait");

    // Request raised during WAIT; pointer wraps from 3 to 0
    do_reset();
    r0 = rsp_cnt;
    set_ops(2, 90, 9);
    set_ops(0, 45, 6);
    expect_rsp(2, 10, 0, 1'b0);
    expect_rsp(0, 7, 3, 1'b0);
    Req = 4'b0100;
    wait_gnt(2, "wrap_gnt2");
    Req = 4'b0001;
    wait_gnt(0, "wrap_gnt0");
    Req = '0;
    wait_rsp(r0 + 2, "wrap_rsp_wait");

    // Pointer now 1: slot 3 beats slot 0
    r0 = rsp_cnt;
    set_ops(3, 11, 2);
    set_ops(0, 9, 2);
    expect_rsp(3, 5, 1, 1'b0);
    expect_rsp(0, 4, 1, 1'b0);
    Req = 4'b1001;
    wait_gnt(3, "ptr_gnt3");
    Req = 4'b0001;
    wait_gnt(0, "ptr_gnt0");
    Req = '0;
    wait_rsp(r0 + 2, "ptr_rsp_wait");

    // Reset during WAIT: outputs clear at once, pending result never delivered
    r0 = rsp_cnt;
    set_ops(1, 50, 5);
    gq.push_back(1);
    Req = 4'b0010;
    wait_gnt(1, "rst_gnt");
    Req = '0;
    step();
    step();
    s0 = start_cnt;
    RSTa = 1'b0;
    #1;
    check_zero("midrst");
    step();
    step();
    RSTa = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("midrst_no_rsp", 64'(rsp_cnt), 64'(r0));
    check("midrst_no_start", 64'(start_cnt), 64'(s0));
    check("midrst_busy", 64'(Busy), 64'(0));
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
